// File: rtl/aes_inv_cipher_pkg.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher_pkg
// Shared definitions for the AES-128 inverse cipher:
//   - fsm_t       : controller states (IDLE, RUN)
//   - NUM_ROUNDS  : AES-128 round count
//   - SBOX        : forward S-box (used when stepping the key schedule backwards)
//   - INV_SBOX    : inverse S-box (InvSubBytes)
//   - RCON        : round constants, indexed directly by the round counter (1..10)
//   - xtime/gmul  : GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
// -----------------------------------------------------------------------------
package aes_inv_cipher_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Index 0 and 11..15 are never used by a legal round counter; kept zero.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (b[i] ? aa : 8'h00);
      aa  = xtime(aa);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// -----------------------------------------------------------------------------
// aes_inv_round
// One combinational AES inverse round:
//   ostate = [InvMixColumns]( InvSubBytes(InvShiftRows(istate)) ^ rkey )
// Ports:
//   istate [127:0]  state entering the round (byte i = row i%4, column i/4)
//   rkey   [127:0]  round key added after InvSubBytes
//   bypass          1 = skip InvMixColumns (final round)
//   ostate [127:0]  round result
// -----------------------------------------------------------------------------
module aes_inv_round
  import aes_inv_cipher_pkg::*;
(
  input  logic [127:0] istate,
  input  logic [127:0] rkey,
  input  logic         bypass,
  output logic [127:0] ostate
);

  logic [127:0] shifted_s;
  logic [127:0] subbed_s;
  logic [127:0] keyed_s;
  logic [127:0] mixed_s;

  // InvShiftRows: row r rotates right by r columns.
  always_comb begin
    shifted_s = 128'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted_s[8*(r+4*c) +: 8] = istate[8*(r+4*((c-r+4)%4)) +: 8];
      end
    end
  end

  // InvSubBytes followed by AddRoundKey.
  always_comb begin
    subbed_s = 128'd0;
    for (int i = 0; i < 16; i++) begin
      subbed_s[8*i +: 8] = INV_SBOX[shifted_s[8*i +: 8]];
    end
    keyed_s = subbed_s ^ rkey;
  end

  // InvMixColumns: circulant matrix {0e,0b,0d,09} applied per column.
  always_comb begin
    mixed_s = 128'd0;
    for (int c = 0; c < 4; c++) begin
      mixed_s[32*c +: 8]    = gmul(8'h0e, keyed_s[32*c +: 8])    ^ gmul(8'h0b, keyed_s[32*c+8 +: 8]) ^
                              gmul(8'h0d, keyed_s[32*c+16 +: 8]) ^ gmul(8'h09, keyed_s[32*c+24 +: 8]);
      mixed_s[32*c+8 +: 8]  = gmul(8'h09, keyed_s[32*c +: 8])    ^ gmul(8'h0e, keyed_s[32*c+8 +: 8]) ^
                              gmul(8'h0b, keyed_s[32*c+16 +: 8]) ^ gmul(8'h0d, keyed_s[32*c+24 +: 8]);
      mixed_s[32*c+16 +: 8] = gmul(8'h0d, keyed_s[32*c +: 8])    ^ gmul(8'h09, keyed_s[32*c+8 +: 8]) ^
                              gmul(8'h0e, keyed_s[32*c+16 +: 8]) ^ gmul(8'h0b, keyed_s[32*c+24 +: 8]);
      mixed_s[32*c+24 +: 8] = gmul(8'h0b, keyed_s[32*c +: 8])    ^ gmul(8'h0d, keyed_s[32*c+8 +: 8]) ^
                              gmul(8'h09, keyed_s[32*c+16 +: 8]) ^ gmul(8'h0e, keyed_s[32*c+24 +: 8]);
    end
  end

  // Output select: final round drops InvMixColumns.
  always_comb begin
    if (bypass) begin
      ostate = keyed_s;
    end else begin
      ostate = mixed_s;
    end
  end

endmodule

// File: rtl/aes_inv_cipher.sv
// -----------------------------------------------------------------------------
// aes_inv_cipher
// Iterative AES-128 decryptor, one round per clock, 10 busy cycles per block.
// The round key is recovered on the fly by running the key schedule backwards
// from the final round key K10, so the cipher key K0 pops out with the result.
// Ports:
//   clock          rising-edge clock
//   resetn         asynchronous active-low reset
//   start          begin a block (sampled only while busy=0)
//   i_text [127:0] ciphertext
//   key    [127:0] final round key K10
//   o_text [127:0] recovered plaintext (holds until next completion)
//   o_key  [127:0] recovered cipher key K0 (holds until next completion)
//   busy           block in progress
//   done           one-cycle pulse when o_text/o_key update
// -----------------------------------------------------------------------------
module aes_inv_cipher
  import aes_inv_cipher_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] i_text,
  input  logic [127:0] key,
  output logic [127:0] o_text,
  output logic [127:0] o_key,
  output logic         busy,
  output logic         done
);

  fsm_t         fsm_r;
  logic [3:0]   cnt_r;
  logic [127:0] state_r;
  logic [127:0] rkey_r;

  logic [31:0]  p0_s, p1_s, p2_s, p3_s;
  logic [31:0]  rot_s, sub_s;
  logic [127:0] prev_key_s;
  logic [127:0] round_out_s;
  logic         last_s;
  logic         cnt_bad_s;

  // Inverse key expansion: derive K(cnt-1) from K(cnt) held in rkey_r.
  always_comb begin
    p3_s  = rkey_r[127:96] ^ rkey_r[95:64];
    p2_s  = rkey_r[95:64]  ^ rkey_r[63:32];
    p1_s  = rkey_r[63:32]  ^ rkey_r[31:0];
    // RotWord moves byte 1 into byte 0 position.
    rot_s = {p3_s[7:0], p3_s[31:8]};
    sub_s = {SBOX[rot_s[31:24]], SBOX[rot_s[23:16]], SBOX[rot_s[15:8]], SBOX[rot_s[7:0]]};
    p0_s  = rkey_r[31:0] ^ sub_s ^ {24'h000000, RCON[cnt_r]};
    prev_key_s = {p3_s, p2_s, p1_s, p0_s};
  end

  // Round-position decode.
  always_comb begin
    last_s    = (cnt_r == 4'd1);
    cnt_bad_s = (cnt_r == 4'd0) || (cnt_r > NUM_ROUNDS);
  end

  aes_inv_round u_round (
    .istate (state_r),
    .rkey   (prev_key_s),
    .bypass (last_s),
    .ostate (round_out_s)
  );

  // Controller FSM with all datapath and output registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm_r   <= IDLE;
      cnt_r   <= 4'd0;
      state_r <= 128'd0;
      rkey_r  <= 128'd0;
      o_text  <= 128'd0;
      o_key   <= 128'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r <= i_text ^ key;
            rkey_r  <= key;
            cnt_r   <= NUM_ROUNDS;
            busy    <= 1'b1;
            fsm_r   <= RUN;
          end else begin
            fsm_r   <= IDLE;
          end
        end
        RUN: begin
          if (cnt_bad_s) begin
            // Corrupted counter: abandon the block without a done pulse.
            cnt_r <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            fsm_r <= IDLE;
          end else if (last_s) begin
            o_text <= round_out_s;
            o_key  <= prev_key_s;
            cnt_r  <= 4'd0;
            done   <= 1'b1;
            busy   <= 1'b0;
            fsm_r  <= IDLE;
          end else begin
            state_r <= round_out_s;
            rkey_r  <= prev_key_s;
            cnt_r   <= cnt_r - 4'd1;
            done    <= 1'b0;
          end
        end
        default: begin
          cnt_r <= 4'd0;
          busy  <= 1'b0;
          done  <= 1'b0;
          fsm_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_inv_cipher.md
AES_INV_CIPHER -- requirements
Module: aes_inv_cipher

Interface
REQ-001 Parameters: none; the block is fixed at AES-128 with 10 rounds.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to decrypt i_text with key; sampled only while busy=0.
REQ-005 i_text  input  128  ciphertext block.
REQ-006 key  input  128  final (round-10) round key K10 of the encryption schedule.
REQ-007 o_text  output  128  recovered plaintext, registered.
REQ-008 o_key  output  128  recovered cipher key K0, registered.
REQ-009 busy  output  1  high while a block is in progress.
REQ-010 done  output  1  one-cycle pulse; o_text and o_key are valid in this cycle.
REQ-011 Byte order: byte i occupies bits [8i+7:8i]; state byte i is row i%4, column i/4; key words are byte-ordered the same way.

Function
REQ-012 FSM states: IDLE and RUN; a 4-bit round counter cnt.
REQ-013 IDLE with start=1 at edge t: state <= i_text XOR key; rkey <= key; cnt <= 10; busy <= 1; go to RUN.
REQ-014 IDLE with start=0: registers hold; done=0.
REQ-015 RUN, each edge, compute the previous round key: K(cnt-1) = inverse key expansion of rkey using Rcon[cnt], where Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-016 RUN, each edge, when cnt>1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) XOR K(cnt-1)); rkey <= K(cnt-1); cnt <= cnt-1.
REQ-017 RUN, when cnt=1: InvMixColumns is bypassed; o_text <= InvSubBytes(InvShiftRows(state)) XOR K0; o_key <= K0; done <= 1; busy <= 0; go to IDLE.
REQ-018 Latency: start sampled at edge t gives done=1 in the cycle after edge t+10, i.e. 10 cycles of busy.
REQ-019 Throughput: start may be accepted in the same cycle that done=1 (back-to-back blocks every 11 cycles).
REQ-020 start while busy=1 is ignored: no queueing and no effect on the block in progress.
REQ-021 i_text and key are sampled only at the start edge; later changes have no effect.
REQ-022 o_text and o_key hold their last completed values until the next completion.
REQ-023 done is exactly one cycle wide per block and is never asserted without a preceding accepted start.
REQ-024 cnt never leaves the range 1..10 in RUN; a value outside that range forces IDLE.

Reset
REQ-025 resetn=0 immediately (asynchronously) forces IDLE with o_text=0, o_key=0, busy=0, done=0, cnt=0, and internal state and rkey cleared.
REQ-026 Reset mid-operation aborts the block; no done is produced for it.
REQ-027 After reset releases, the first start is accepted at the first rising edge where resetn=1.

Structure
REQ-028 A shared package holds the inverse S-box table, the forward S-box table (needed by key inversion), the Rcon table, and the GF(2^8) xtime/multiply functions.
REQ-029 One combinational sub-module, aes_inv_round (ports: istate, rkey, bypass, ostate), implements InvShiftRows, InvSubBytes, AddRoundKey and optional InvMixColumns.
REQ-030 The inverse key step, FSM and registers are in aes_inv_cipher.

Verification
REQ-031 FIPS-197 C.1: key=128'hc5302b4d8ba707f3174a94e37f1d1113, i_text=128'h5ac5b47080b7cdd830047b6ad8e0c469, start pulse -> done after 10 busy cycles, o_text=128'hffeeddccbbaa99887766554433221100, o_key=128'h0f0e0d0c0b0a09080706050403020100.
REQ-032 Back-to-back: hold start=1 continuously with the C.1 vector -> done pulses every 11 cycles and every result is correct.
REQ-033 Start while busy: pulse start with garbage inputs at busy cycles 3 and 9 -> the C.1 result is unchanged and there is exactly one done.
REQ-034 Input change: change i_text and key on the cycle after start -> the C.1 result is unchanged.
REQ-035 Reset abort: assert resetn=0 at busy cycle 5 -> outputs are immediately zero, no done follows, and a fresh start after release gives the correct C.1 result.
REQ-036 Random: 1000 random keys and plaintexts, encrypted with the reference model to get the ciphertext and K10 -> o_text equals the plaintext and o_key equals the key for every block.
